// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
// Byte-stream front end for the SHA-256 compression core. Collects message
// bytes into a 64-byte block, appends the 0x80 marker, zero fill and the
// 64-bit big-endian bit length, and hands each finished block to the core
// through a start/done handshake. blk_first / blk_final tag each block so the
// surrounding logic can chain intermediate hash values.
//
// Handshakes:
//   input stream : a beat transfers on a rising edge where msg_valid && msg_ready;
//                  msg_ready depends only on registered state, never on msg_valid.
//   core         : blk_start stays high until blk_done is sampled high, then
//                  drops on that edge; no new blk_start until blk_done is seen low.
module sha256_msg_padder (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   msg_data,
   input  logic         msg_valid,
   input  logic         msg_last,
   input  logic         msg_empty,
   output logic         msg_ready,
   output logic [511:0] blk_words,
   output logic         blk_start,
   input  logic         blk_done,
   output logic         blk_first,
   output logic         blk_final,
   output logic [2:0]   dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FILL     = 3'd1,
      S_PAD      = 3'd2,
      S_LEN      = 3'd3,
      S_SEND     = 3'd4,
      S_WAIT_LOW = 3'd5
   } state_t;

   state_t        state;
   logic [511:0]  buffer;        // byte 0 of the block lives in [511:504]
   logic [6:0]    ptr;           // next byte position, 0..64
   logic [60:0]   len;           // message length in bytes, wraps mod 2^61
   logic          pad_pending;   // block filled exactly by the last byte: marker goes in the next block
   logic          len_pending;   // marker landed past byte 55: length goes in the next block
   logic          first;         // next block sent is the first of its message

   logic          accept;
   logic [6:0]    ptr_next;
   logic [8:0]    byte_lsb;      // bit index of the low bit of buffer byte 'ptr'

   assign msg_ready = (state == S_FILL) && (ptr < 7'd64);
   assign accept    = msg_valid && msg_ready;
   assign ptr_next  = msg_empty ? ptr : ptr + 7'd1;
   assign byte_lsb  = 9'd504 - {ptr[5:0], 3'b000};
   assign blk_words = buffer;
   assign dbg_state = state;

   // Block assembly and core handshake sequencing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         buffer      <= '0;
         ptr         <= '0;
         len         <= '0;
         pad_pending <= 1'b0;
         len_pending <= 1'b0;
         first       <= 1'b0;
         blk_start   <= 1'b0;
         blk_first   <= 1'b0;
         blk_final   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               buffer      <= '0;
               ptr         <= '0;
               len         <= '0;
               first       <= 1'b1;
               pad_pending <= 1'b0;
               len_pending <= 1'b0;
               // The beat that wakes us up is taken in FILL, not here.
               if (msg_valid) state <= S_FILL;
            end

            S_FILL: begin
               if (accept) begin
                  if (!msg_empty) begin
                     buffer[byte_lsb +: 8] <= msg_data;
                     len                   <= len + 61'd1;
                  end
                  ptr <= ptr_next;
                  if (msg_last) begin
                     if (ptr_next < 7'd64) begin
                        state <= S_PAD;
                     end else begin
                        pad_pending <= 1'b1;
                        blk_first   <= first;
                        blk_final   <= 1'b0;
                        state       <= S_SEND;
                     end
                  end else if (ptr_next == 7'd64) begin
                     blk_first <= first;
                     blk_final <= 1'b0;
                     state     <= S_SEND;
                  end
               end
            end

            S_PAD: begin
               // ptr < 64 is guaranteed on entry, so the marker always fits.
               buffer[byte_lsb +: 8] <= 8'h80;
               ptr                   <= ptr + 7'd1;
               if ((ptr + 7'd1) <= 7'd56) begin
                  state <= S_LEN;
               end else begin
                  len_pending <= 1'b1;
                  blk_first   <= first;
                  blk_final   <= 1'b0;
                  state       <= S_SEND;
               end
            end

            S_LEN: begin
               buffer[63:0] <= {len, 3'b000};
               blk_first    <= first;
               blk_final    <= 1'b1;
               state        <= S_SEND;
            end

            S_SEND: begin
               // One settle cycle with the block registered, then request the core.
               if (!blk_start) begin
                  blk_start <= 1'b1;
               end else if (blk_done) begin
                  blk_start <= 1'b0;
                  state     <= S_WAIT_LOW;
               end
            end

            S_WAIT_LOW: begin
               if (!blk_done) begin
                  buffer <= '0;
                  ptr    <= '0;
                  first  <= 1'b0;
                  if (pad_pending) begin
                     pad_pending <= 1'b0;
                     state       <= S_PAD;
                  end else if (len_pending) begin
                     len_pending <= 1'b0;
                     ptr         <= 7'd56;
                     state       <= S_LEN;
                  end else if (blk_final) begin
                     state <= S_IDLE;
                  end else begin
                     state <= S_FILL;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
